// File: rtl/sram_access_arbiter.sv
// Round-robin two-port arbiter and phase sequencer for a single compiled SRAM macro.
// Sole driver of the macro pins: precharge (SETUP), sense/write, recover.
module sram_access_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int SENSE_CYC = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int MAXC = (SETUP_CYC > SENSE_CYC) ? SETUP_CYC : SENSE_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] SENSE_LAST = CW'(SENSE_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, WRITE, SENSE, RECOVER} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          pri_b;   // 1: B wins a tie (A was served last)
    logic          lat_we;
    logic          lat_b;
    logic          accept;
    logic          rd_done;

    always_comb begin
        state_nx = state;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        case (state)
            IDLE: begin
                gnt_a = resetn & req_a & (~req_b | ~pri_b);
                gnt_b = resetn & req_b & (~req_a | pri_b);
                if (gnt_a | gnt_b) state_nx = SETUP;
            end
            SETUP:   if (cnt == SETUP_LAST) state_nx = lat_we ? WRITE : SENSE;
            WRITE:   state_nx = RECOVER;
            SENSE:   if (cnt == SENSE_LAST) state_nx = RECOVER;
            RECOVER: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign accept  = gnt_a | gnt_b;
    assign rd_done = (state == SENSE) && (state_nx == RECOVER);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            pri_b         <= 1'b0;
            lat_we        <= 1'b0;
            lat_b         <= 1'b0;
            sram_addr     <= '0;
            sram_din      <= '0;
            sram_write_en <= 1'b0;
            sram_sense_en <= 1'b0;
            rvalid_a      <= 1'b0;
            rvalid_b      <= 1'b0;
            rdata_a       <= '0;
            rdata_b       <= '0;
        end else begin
            state <= state_nx;
            // phase counter restarts on every state entry and idles at zero
            cnt   <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;
            if (accept) begin
                lat_we    <= gnt_b ? we_b : we_a;
                lat_b     <= gnt_b;
                sram_addr <= gnt_b ? addr_b : addr_a;
                sram_din  <= gnt_b ? wdata_b : wdata_a;
                pri_b     <= gnt_a;
            end
            // macro strobes decoded from next state so they flop out glitch-free
            sram_write_en <= (state_nx == WRITE);
            sram_sense_en <= (state_nx == WRITE) || (state_nx == SENSE);
            rvalid_a      <= rd_done & ~lat_b;
            rvalid_b      <= rd_done & lat_b;
            if (rd_done) begin
                if (lat_b) rdata_b <= sram_dout;
                else       rdata_a <= sram_dout;
            end
        end
    end

endmodule
